// File: rtl/core_pkg.sv
// Shared types for the writeback controller: load size encodings,
// the pending-load entry layout, queue occupancy states and the
// load-data alignment/extension helper.
package core_pkg;

  typedef enum logic [1:0] {
    LD_B  = 2'b00,
    LD_H  = 2'b01,
    LD_W  = 2'b10,
    LD_WX = 2'b11  // reserved encoding, behaves as a word load
  } ld_size_e;

  typedef struct packed {
    logic [4:0] rd;
    ld_size_e   size;
    logic       uns;
    logic [1:0] off;
  } ld_entry_t;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'b00,
    Q_PART  = 2'b01,
    Q_FULL  = 2'b10
  } q_state_e;

  // Align the raw memory word to the addressed byte lane, then trim to
  // the access size and sign- or zero-extend back to 32 bits.
  function automatic logic [31:0] ld_extract(input logic [31:0] raw,
                                             input ld_size_e    size,
                                             input logic        uns,
                                             input logic [1:0]  off);
    logic [31:0] sh;
    logic [31:0] res;
    sh = raw >> {off, 3'b000};
    case (size)
      LD_B:    res = {{24{~uns & sh[7]}}, sh[7:0]};
      LD_H:    res = {{16{~uns & sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/core_ld_fifo.sv
// Pending-load queue. Holds load descriptors in issue order and exports
// every slot with its valid bit so the decoder can check for hazards.
// A push into a full queue is accepted only when a pop happens in the
// same cycle.
module core_ld_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  ld_entry_t             push_entry_i,
  input  logic                  pop_i,
  output ld_entry_t             head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH-1:0]      valid_o,
  output ld_entry_t [DEPTH-1:0] entries_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ld_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  q_state_e         state_q, state_d;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [PTR_W-1:0] ofs_s;

  assign full_o  = (state_q == Q_FULL);
  assign empty_o = (state_q == Q_EMPTY);
  assign head_o  = mem_q[rd_ptr_q];

  // Accept decisions plus next pointer, count and occupancy state.
  always_comb begin
    pop_ok_s  = pop_i & ~empty_o;
    push_ok_s = push_i & (~full_o | pop_ok_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    state_d   = state_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (count_d == CNT_W'(0)) begin
      state_d = Q_EMPTY;
    end else if (count_d == CNT_W'(DEPTH)) begin
      state_d = Q_FULL;
    end else begin
      state_d = Q_PART;
    end
  end

  // Queue bookkeeping registers; reset empties the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= Q_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Entry storage; contents are meaningless until marked valid.
  always_ff @(posedge clk_i) begin
    if (push_ok_s && !rst_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    valid_o = '0;
    ofs_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ofs_s      = PTR_W'(i) - rd_ptr_q;
      valid_o[i] = ({1'b0, ofs_s} < count_q);
      entries_o[i] = mem_q[i];
    end
  end

endmodule

// File: rtl/core_wb_ctrl.sv
// Register-file writeback controller. Arbitrates between ALU results
// and returning loads (ALU wins), aligns/extends load data, tracks
// outstanding loads for hazard detection and flags queue overflow.
module core_wb_ctrl
  import core_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_vld,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  input  logic [1:0]  ld_size,
  input  logic        ld_uns,
  input  logic [1:0]  ld_off,
  output logic        ld_full,
  input  logic        mem_rsp_vld,
  input  logic [31:0] mem_rsp_data,
  output logic        mem_rsp_rdy,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        hazard,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        ld_ovf
);

  ld_entry_t                push_entry_s;
  ld_entry_t                head_s;
  logic                     ld_full_s;
  logic                     ld_empty_s;
  logic [LD_DEPTH-1:0]      ld_valid_s;
  ld_entry_t [LD_DEPTH-1:0] ld_ents_s;
  logic                     rsp_rdy_s;
  logic                     ld_pop_s;
  logic                     hazard_s;

  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        ld_ovf_q, ld_ovf_d;

  assign push_entry_s = '{rd: ld_rd, size: ld_size_e'(ld_size), uns: ld_uns, off: ld_off};
  assign rsp_rdy_s    = ~ld_empty_s & ~alu_vld;
  assign ld_pop_s     = mem_rsp_vld & rsp_rdy_s;

  core_ld_fifo #(
    .DEPTH(LD_DEPTH)
  ) u_ld_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (ld_issue),
    .push_entry_i(push_entry_s),
    .pop_i       (ld_pop_s),
    .head_o      (head_s),
    .full_o      (ld_full_s),
    .empty_o     (ld_empty_s),
    .valid_o     (ld_valid_s),
    .entries_o   (ld_ents_s)
  );

  // Hazard when any live pending load targets a non-zero source register.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (ld_valid_s[i] && (ld_ents_s[i].rd != 5'd0) &&
          ((ld_ents_s[i].rd == chk_rs1) || (ld_ents_s[i].rd == chk_rs2))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // Writeback selection (ALU first) and sticky overflow next-state.
  always_comb begin
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    ld_ovf_d  = ld_ovf_q | (ld_issue & ld_full_s & ~ld_pop_s);
    if (alu_vld) begin
      wb_we_d   = (alu_rd != 5'd0);
      wb_rd_d   = alu_rd;
      wb_data_d = alu_data;
    end else if (ld_pop_s) begin
      wb_we_d   = (head_s.rd != 5'd0);
      wb_rd_d   = head_s.rd;
      wb_data_d = ld_extract(mem_rsp_data, head_s.size, head_s.uns, head_s.off);
    end else begin
      wb_we_d   = 1'b0;
    end
  end

  // Writeback port and overflow flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
      ld_ovf_q  <= 1'b0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      ld_ovf_q  <= ld_ovf_d;
    end
  end

  assign ld_full     = ld_full_s;
  assign mem_rsp_rdy = rsp_rdy_s;
  assign hazard      = hazard_s;
  assign wb_we       = wb_we_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign ld_ovf      = ld_ovf_q;

endmodule

// File: tb/tb_core_wb_ctrl.sv
// Scoreboard bench for core_wb_ctrl: expected writebacks are queued when
// stimulus is driven and matched against wb_* by a monitor.
module tb_core_wb_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, alu_vld, ld_issue, ld_uns, mem_rsp_vld;
  logic [4:0]  alu_rd, ld_rd, chk_rs1, chk_rs2;
  logic [31:0] alu_data, mem_rsp_data;
  logic [1:0]  ld_size, ld_off;
  logic        ld_full, mem_rsp_rdy, hazard, wb_we, ld_ovf;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct {
    logic [4:0] rd;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } ld_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } wb_t;

  ld_t ld_model[$];
  wb_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  core_wb_ctrl #(.LD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_vld(alu_vld), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_size(ld_size), .ld_uns(ld_uns), .ld_off(ld_off),
    .ld_full(ld_full),
    .mem_rsp_vld(mem_rsp_vld), .mem_rsp_data(mem_rsp_data), .mem_rsp_rdy(mem_rsp_rdy),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ld_ovf(ld_ovf)
  );

  function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns,
                                           input logic [1:0] off, input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    case (off)
      2'd0:    begin b = raw[7:0];   h = raw[15:0];          w = raw;                   end
      2'd1:    begin b = raw[15:8];  h = raw[23:8];          w = {8'h00, raw[31:8]};    end
      2'd2:    begin b = raw[23:16]; h = raw[31:16];         w = {16'h0000, raw[31:16]}; end
      default: begin b = raw[31:24]; h = {8'h00, raw[31:24]}; w = {24'h000000, raw[31:24]}; end
    endcase
    if (size == 2'b00) return uns ? {24'h000000, b} : {{24{b[7]}}, b};
    else if (size == 2'b01) return uns ? {16'h0000, h} : {{16{h[15]}}, h};
    else return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_t e;
    if (rd != 5'd0) begin
      e.rd = rd; e.data = data; e.due = edge_cnt + 1;
      sb.push_back(e);
    end
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
    alu_vld = 1'b1; alu_rd = rd; alu_data = data;
    expect_wb(rd, data);
    step();
    alu_vld = 1'b0;
  endtask

  task automatic drive_issue(input logic [4:0] rd, input logic [1:0] size,
                             input logic uns, input logic [1:0] off);
    ld_t e;
    ld_issue = 1'b1; ld_rd = rd; ld_size = size; ld_uns = uns; ld_off = off;
    if (ld_model.size() < DEPTH) begin
      e.rd = rd; e.size = size; e.uns = uns; e.off = off;
      ld_model.push_back(e);
    end
    step();
    ld_issue = 1'b0;
  endtask

  task automatic model_pop(input logic [31:0] raw);
    ld_t e;
    if (ld_model.size() > 0) begin
      e = ld_model.pop_front();
      expect_wb(e.rd, exp_load(e.size, e.uns, e.off, raw));
    end
  endtask

  task automatic drive_rsp(input logic [31:0] raw);
    mem_rsp_vld = 1'b1; mem_rsp_data = raw;
    model_pop(raw);
    step();
    mem_rsp_vld = 1'b0;
  endtask

  task automatic sb_monitor();
    wb_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due < edge_cnt) begin
        e = sb.pop_front();
        checks++; errors++;
        $display("FAIL sb_missing: no write seen, want rd=%0d data=%h due edge %0d", e.rd, e.data, e.due);
      end
      if (wb_we === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got write rd=%0d data=%h, want none", wb_rd, wb_data);
        end else begin
          e = sb.pop_front();
          if (wb_rd !== e.rd || wb_data !== e.data || e.due != edge_cnt) begin
            errors++;
            $display("FAIL sb_write: got rd=%0d data=%h edge %0d, want rd=%0d data=%h edge %0d",
                     wb_rd, wb_data, edge_cnt, e.rd, e.data, e.due);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", wb_we); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL rst_rd: got %0d want 0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL rst_data: got %h want 0", wb_data); end
    checks++; if (ld_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", ld_full); end
    checks++; if (ld_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ld_ovf); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rst_hazard: got %b want 0", hazard); end
    rst = 1'b0;
    step();
    mem_rsp_vld = 1'b1; mem_rsp_data = 32'hA5A5_A5A5;
    #1;
    checks++; if (mem_rsp_rdy !== 1'b0) begin errors++; $display("FAIL empty_rdy: got %b want 0", mem_rsp_rdy); end
    step();
    mem_rsp_vld = 1'b0;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL empty_rsp_we: got %b want 0", wb_we); end
  endtask

  task automatic test_alu();
    drive_alu(5'd5, 32'hDEAD_BEEF);
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL alu_basic: got we=%b rd=%0d data=%h want 1/5/deadbeef", wb_we, wb_rd, wb_data);
    end
    step();
    checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd5 || wb_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL idle_hold: got we=%b rd=%0d data=%h want 0/5/deadbeef", wb_we, wb_rd, wb_data);
    end
    drive_alu(5'd0, 32'h1234_5678);
    checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h1234_5678) begin
      errors++; $display("FAIL alu_x0: got we=%b rd=%0d data=%h want 0/0/12345678", wb_we, wb_rd, wb_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      drive_alu(5'(i + 10), $urandom);
    end
    step();
  endtask

  task automatic test_load_ext();
    logic [31:0] raws [7];
    drive_issue(5'd3, 2'b00, 1'b0, 2'd2);
    drive_rsp(32'h1280_3456);
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL ld_byte_signed: got we=%b rd=%0d data=%h want 1/3/ffffff80", wb_we, wb_rd, wb_data);
    end
    raws[0] = 32'h1280_3456; raws[1] = 32'h8001_0000; raws[2] = 32'h00F0_0F00;
    raws[3] = 32'hCAFE_F00D; raws[4] = 32'h0BAD_F00D; raws[5] = 32'h7F00_0000;
    raws[6] = 32'h8899_AABB;
    drive_issue(5'd4,  2'b00, 1'b1, 2'd2);
    drive_issue(5'd6,  2'b01, 1'b0, 2'd2);
    drive_issue(5'd8,  2'b01, 1'b1, 2'd1);
    drive_issue(5'd9,  2'b10, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) drive_rsp(raws[i]);
    drive_issue(5'd10, 2'b11, 1'b1, 2'd0);
    drive_issue(5'd11, 2'b00, 1'b0, 2'd3);
    drive_issue(5'd12, 2'b01, 1'b0, 2'd3);
    for (int i = 4; i < 7; i++) drive_rsp(raws[i]);
    drive_issue(5'd0, 2'b01, 1'b0, 2'd0);
    drive_rsp(32'h0000_9ABC);
    checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'hFFFF_9ABC) begin
      errors++; $display("FAIL ld_x0: got we=%b rd=%0d data=%h want 0/0/ffff9abc", wb_we, wb_rd, wb_data);
    end
  endtask

  task automatic test_collision();
    drive_issue(5'd12, 2'b10, 1'b0, 2'd0);
    alu_vld = 1'b1; alu_rd = 5'd13; alu_data = 32'hA1A2_A3A4;
    mem_rsp_vld = 1'b1; mem_rsp_data = 32'h55AA_55AA;
    #1;
    checks++; if (mem_rsp_rdy !== 1'b0) begin errors++; $display("FAIL coll_rdy_alu: got %b want 0", mem_rsp_rdy); end
    expect_wb(5'd13, 32'hA1A2_A3A4);
    step();
    alu_vld = 1'b0;
    #1;
    checks++; if (mem_rsp_rdy !== 1'b1) begin errors++; $display("FAIL coll_rdy_after: got %b want 1", mem_rsp_rdy); end
    model_pop(32'h55AA_55AA);
    step();
    mem_rsp_vld = 1'b0;
    checks++; if (wb_rd !== 5'd12 || wb_data !== 32'h55AA_55AA) begin
      errors++; $display("FAIL coll_load: got rd=%0d data=%h want 12/55aa55aa", wb_rd, wb_data);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) drive_issue(5'(16 + i), 2'b10, 1'b0, 2'd0);
    checks++; if (ld_full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", ld_full); end
    ld_issue = 1'b1; ld_rd = 5'd20; ld_size = 2'b10; ld_uns = 1'b0; ld_off = 2'd0;
    mem_rsp_vld = 1'b1; mem_rsp_data = 32'h1600_0016;
    model_pop(32'h1600_0016);
    ld_model.push_back('{rd: 5'd20, size: 2'b10, uns: 1'b0, off: 2'd0});
    #1;
    checks++; if (mem_rsp_rdy !== 1'b1) begin errors++; $display("FAIL full_pp_rdy: got %b want 1", mem_rsp_rdy); end
    step();
    ld_issue = 1'b0; mem_rsp_vld = 1'b0;
    checks++; if (ld_ovf !== 1'b0 || ld_full !== 1'b1) begin
      errors++; $display("FAIL full_pushpop: got ovf=%b full=%b want 0/1", ld_ovf, ld_full);
    end
    drive_issue(5'd21, 2'b10, 1'b0, 2'd0);
    checks++; if (ld_ovf !== 1'b1 || ld_full !== 1'b1) begin
      errors++; $display("FAIL full_ovf: got ovf=%b full=%b want 1/1", ld_ovf, ld_full);
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (mem_rsp_rdy !== 1'b1) begin errors++; $display("FAIL drain_rdy%0d: got %b want 1", i, mem_rsp_rdy); end
      drive_rsp(32'h3000_0000 + 32'(i));
    end
    chk_rs1 = 5'd21;
    #1;
    checks++; if (mem_rsp_rdy !== 1'b0 || ld_full !== 1'b0 || hazard !== 1'b0) begin
      errors++; $display("FAIL drained: got rdy=%b full=%b haz=%b want 0/0/0", mem_rsp_rdy, ld_full, hazard);
    end
    checks++; if (ld_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ld_ovf); end
    chk_rs1 = 5'd0;
  endtask

  task automatic test_hazard();
    drive_issue(5'd7, 2'b10, 1'b0, 2'd0);
    drive_issue(5'd0, 2'b10, 1'b0, 2'd0);
    chk_rs2 = 5'd7; #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_rs2: got %b want 1", hazard); end
    chk_rs2 = 5'd0; chk_rs1 = 5'd0; #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL haz_x0: got %b want 0", hazard); end
    chk_rs1 = 5'd8; #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL haz_miss: got %b want 0", hazard); end
    chk_rs1 = 5'd9;
    ld_issue = 1'b1; ld_rd = 5'd9; ld_size = 2'b10; ld_uns = 1'b0; ld_off = 2'd0;
    ld_model.push_back('{rd: 5'd9, size: 2'b10, uns: 1'b0, off: 2'd0});
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL haz_push: got %b want 0", hazard); end
    step();
    ld_issue = 1'b0; #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_pushed: got %b want 1", hazard); end
    chk_rs1 = 5'd7;
    mem_rsp_vld = 1'b1; mem_rsp_data = 32'h0000_0777;
    model_pop(32'h0000_0777);
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_pop: got %b want 1", hazard); end
    step();
    mem_rsp_vld = 1'b0; #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL haz_popped: got %b want 0", hazard); end
    chk_rs1 = 5'd0;
    drive_rsp(32'h0000_0000);
    drive_rsp(32'h0000_0999);
  endtask

  task automatic test_reset_mid();
    drive_issue(5'd22, 2'b10, 1'b0, 2'd0);
    drive_issue(5'd23, 2'b10, 1'b0, 2'd0);
    chk_rs1 = 5'd22; #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL mid_haz_pre: got %b want 1", hazard); end
    rst = 1'b1; alu_vld = 1'b1; alu_rd = 5'd5; alu_data = 32'h0BAD_0BAD;
    step();
    rst = 1'b0; alu_vld = 1'b0;
    ld_model.delete();
    #1;
    checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
      errors++; $display("FAIL mid_wb: got we=%b rd=%0d data=%h want 0/0/0", wb_we, wb_rd, wb_data);
    end
    checks++; if (ld_full !== 1'b0 || hazard !== 1'b0 || ld_ovf !== 1'b0) begin
      errors++; $display("FAIL mid_flags: got full=%b haz=%b ovf=%b want 0/0/0", ld_full, hazard, ld_ovf);
    end
    mem_rsp_vld = 1'b1; mem_rsp_data = 32'h2222_2222; #1;
    checks++; if (mem_rsp_rdy !== 1'b0) begin errors++; $display("FAIL mid_rdy: got %b want 0", mem_rsp_rdy); end
    step();
    mem_rsp_vld = 1'b0;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL mid_nowrite: got %b want 0", wb_we); end
    chk_rs1 = 5'd0;
  endtask

  initial begin
    rst = 1'b1; alu_vld = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_issue = 1'b0; ld_rd = 5'd0; ld_size = 2'b00; ld_uns = 1'b0; ld_off = 2'd0;
    mem_rsp_vld = 1'b0; mem_rsp_data = 32'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    fork
      sb_monitor();
    join_none
    step();
    step();
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_ext();
    test_collision();
    test_full();
    test_hazard();
    test_reset_mid();
    step();
    step();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
